// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Also used by benches that need the reset PC or a known instruction encoding.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT_RSP,
    HOLD,
    WAIT_PC,
    FAULT
  } ifu_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_fetch_reg.sv
// Generic enabled register with a parameterised reset value.
// The fetch unit uses it to hold the PC.
module ifu_fetch_reg #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_q <= RESET_VAL;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Non-speculative instruction fetch unit: one request on the memory bus per instruction,
// the fetched word handed to decode, then a wait for the core's dynamic next PC.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int           AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(ifu_fetch_pkg::RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  input  logic          rsp_valid,
  output logic          rsp_ready,
  input  logic [31:0]   rsp_data,
  input  logic          rsp_err,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [31:0]   inst,
  output logic [AW-1:0] inst_pc,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_dnpc,
  output logic          fault,
  output logic [AW-1:0] fault_pc,
  output logic [31:0]   fetch_cnt
);

  ifu_state_t    r_state;
  logic [31:0]   r_inst;
  logic [AW-1:0] r_inst_pc;
  logic [AW-1:0] r_fault_pc;
  logic [31:0]   r_fetch_cnt;

  logic [AW-1:0] w_pc;
  logic          w_dnpc_take;
  logic          w_dnpc_ok;
  logic          w_pc_en;

  // A dnpc is taken either together with the decode handshake or later while waiting for it.
  assign w_dnpc_take = wb_valid &&
                       (((r_state == HOLD) && inst_ready) || (r_state == WAIT_PC));
  assign w_dnpc_ok   = is_word_aligned(wb_dnpc[1:0]);
  assign w_pc_en     = w_dnpc_take && w_dnpc_ok;

  ifu_fetch_reg #(
    .W         (AW),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_pc_en),
    .i_d  (wb_dnpc),
    .o_q  (w_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= REQ;
      r_inst      <= '0;
      r_inst_pc   <= '0;
      r_fault_pc  <= '0;
      r_fetch_cnt <= '0;
    end else begin
      case (r_state)
        REQ: begin
          if (req_ready) r_state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            r_inst    <= rsp_data;
            r_inst_pc <= w_pc;
            if (rsp_err) begin
              r_state    <= FAULT;
              r_fault_pc <= w_pc;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (inst_ready) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (!wb_valid)      r_state <= WAIT_PC;
            else if (w_dnpc_ok) r_state <= REQ;
            else begin
              r_state    <= FAULT;
              r_fault_pc <= wb_dnpc;
            end
          end
        end
        WAIT_PC: begin
          if (wb_valid) begin
            if (w_dnpc_ok) r_state <= REQ;
            else begin
              r_state    <= FAULT;
              r_fault_pc <= wb_dnpc;
            end
          end
        end
        FAULT:   r_state <= FAULT;
        default: r_state <= FAULT;
      endcase
    end
  end

  // Handshake outputs decode the state only, so no input reaches them in the same cycle.
  assign req_valid  = (r_state == REQ);
  assign rsp_ready  = (r_state == WAIT_RSP);
  assign inst_valid = (r_state == HOLD);
  assign fault      = (r_state == FAULT);
  assign req_addr   = w_pc;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fault_pc   = r_fault_pc;
  assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit upstream of the single-cycle execute core. It replaces the core's combinational instruction-memory read with a handshaked, multi-cycle fetch.
- Owns the PC and issues one read request per instruction on a valid/ready memory bus.
- Presents the fetched word and its PC to decode with valid/ready.
- Waits for the core to return the dynamic next PC (dnpc) before fetching again. Non-speculative: one instruction in flight.

Parameters:
- RESET_PC, 32'h80000000, PC loaded on reset.
- AW, 32, address/PC width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  out  1  memory read request valid
- req_ready  in  1  memory accepts request
- req_addr  out  AW  word address (= PC)
- rsp_valid  in  1  read data valid
- rsp_ready  out  1  IFU accepts response
- rsp_data  in  32  instruction word
- rsp_err  in  1  bus error with response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  AW  PC of inst
- wb_valid  in  1  core delivers next PC
- wb_dnpc  in  AW  next PC from core
- fault  out  1  sticky fetch fault
- fault_pc  out  AW  PC that faulted
- fetch_cnt  out  32  instructions delivered to decode

Behaviour:
- Reset (async, any state): state=REQ, pc=RESET_PC, req_valid=1 after deassert, rsp_ready=0, inst_valid=0, inst=0, inst_pc=0, fault=0, fault_pc=0, fetch_cnt=0.
- States: REQ, WAIT_RSP, HOLD, WAIT_PC, FAULT.
- REQ
  - req_valid=1, req_addr=pc.
  - Address stays stable until req_valid&req_ready, then go to WAIT_RSP next cycle.
- WAIT_RSP
  - rsp_ready=1. On rsp_valid: latch inst=rsp_data and inst_pc=pc.
  - rsp_err=0: go to HOLD.
  - rsp_err=1: go to FAULT, fault_pc=pc.
  - Response earliest one cycle after request accept. Minimum fetch latency: accept cycle, then response cycle, then inst_valid on the following cycle.
- HOLD
  - inst_valid=1. inst and inst_pc stay stable until inst_ready.
  - On inst_valid&inst_ready: fetch_cnt+=1 (wraps 32'hFFFFFFFF to 0).
  - If wb_valid is asserted in the same cycle (combinational dnpc from a single-cycle core): pc=wb_dnpc and go to REQ. Otherwise go to WAIT_PC.
- WAIT_PC
  - On wb_valid: pc=wb_dnpc, go to REQ.
  - wb_valid is ignored in REQ, WAIT_RSP and FAULT.
- Misaligned dnpc (wb_dnpc[1:0]!=0) on acceptance: go to FAULT with fault_pc=wb_dnpc; pc is not updated.
- rsp_valid outside WAIT_RSP is ignored (rsp_ready=0). The memory must not respond without an accepted request. The memory shares rst, so nothing is outstanding after reset.
- FAULT
  - fault=1, req_valid=0, inst_valid=0. Terminal until rst.
  - fetch_cnt frozen.
- Outputs are registered or decoded from state only; no combinational path from inst_ready/wb_valid to req_valid within the same cycle. req_valid rises the cycle after the HOLD/WAIT_PC exit.
- No bubble injection or flush: exactly one instruction is outstanding at any time.

Decomposition:
- Shared package: ifu_state_t enum (REQ, WAIT_RSP, HOLD, WAIT_PC, FAULT), RESET_PC default constant, INST_EBREAK encoding constant for benches.
- PC register: the team's generic parameterised register with reset value RESET_PC.
- No other sub-module. FSM, output latches and counter stay in ifu_fetch.

Test Plan:
- Reset then req_ready=1, response 2 cycles later with 32'h00000013 -> req_addr=80000000, inst_valid rises, inst=00000013, inst_pc=80000000.
- HOLD with inst_ready=1 and wb_valid=1, wb_dnpc=80000004 in the same cycle -> next cycle req_valid=1, req_addr=80000004, fetch_cnt=1.
- req_ready held low 5 cycles -> req_valid and req_addr=80000000 stable throughout; a single request accepted.
- inst_ready low 3 cycles in HOLD -> inst/inst_pc unchanged; wb_valid pulsed during HOLD is ignored and pc is unchanged.
- Response with rsp_err=1 at pc=80000010 -> fault=1, fault_pc=80000010, req_valid=0 permanently; rst pulse mid-FAULT restores pc=80000000, fault=0.
- wb_dnpc=80000006 -> FAULT with fault_pc=80000006. Separately, preload fetch_cnt near wrap via 2^32 force/backdoor -> counter wraps to 0.
